rx_axis_sink: RTL and testbench

- AXI-Stream consumer at the output end of the RX chain.
- Accepts 64-bit RX beats formatted {Q[15:0], 16'd0, I[15:0], 16'd0}.
- Repacks each beat to a 32-bit {Q, I} word and buffers it in a circular FIFO for the CPU/bus read side.
- Gates capture with a start/stop/sample-count state machine and reports overflow, underflow and fill level.

---
 rtl/rx_pkg.sv | 20 ++
 rtl/sync_fifo_ram.sv | 86 ++++++++
 rtl/rx_axis_sink.sv | 142 ++++++++++++++
 tb/tb_rx_axis_sink.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared RX chain definitions: sink FSM states and the 64-bit beat layout.
// The repack helper turns a {Q, 16'd0, I, 16'd0} beat into a {Q, I} word.
package rx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } rx_sink_state_t;

    localparam int RX_I_MSB = 31;
    localparam int RX_I_LSB = 16;
    localparam int RX_Q_MSB = 63;
    localparam int RX_Q_LSB = 48;

    function automatic logic [31:0] rx_repack(input logic [63:0] beat);
        return {beat[RX_Q_MSB:RX_Q_LSB], beat[RX_I_MSB:RX_I_LSB]};
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Single-clock circular buffer; read data registered one cycle after a pop.
// Pushes while full and pops while empty are ignored; flush beats push and pop.
module sync_fifo_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [DW-1:0] push_dat_i,
    input  logic          pop_i,
    output logic [DW-1:0] rd_dat_o,
    output logic          rd_vld_o,
    output logic [AW:0]   fill_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   fill_q, fill_d;
    logic [DW-1:0] rd_dat_q, rd_dat_d;
    logic          rd_vld_q, rd_vld_d;
    logic          do_push, do_pop;

    assign full_o  = (fill_q == FULL_LVL);
    assign empty_o = (fill_q == '0);
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        rd_dat_d = rd_dat_q;
        rd_vld_d = 1'b0;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                rd_dat_d = mem[rd_ptr_q];
                rd_vld_d = 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   fill_d = fill_q + (AW+1)'(1);
                2'b01:   fill_d = fill_q - (AW+1)'(1);
                default: fill_d = fill_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_dat_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            rd_dat_q <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            rd_dat_q <= rd_dat_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    assign rd_dat_o = rd_dat_q;
    assign rd_vld_o = rd_vld_q;
    assign fill_o   = fill_q;

endmodule

// File: rtl/rx_axis_sink.sv
// AXI-Stream RX sink: repacks beats to {Q, I}, gates capture by start/stop/count; read latency 1.
// Backpressures via tready when full, or with DROP_WHEN_FULL keeps tready high and counts drops.
module rx_axis_sink
    import rx_pkg::*;
#(
    parameter int DEPTH          = 1024,
    parameter int AW             = $clog2(DEPTH),
    parameter int DROP_WHEN_FULL = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] axis_tdata_i,
    input  logic        axis_tvalid_i,
    output logic        axis_tready_o,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic [31:0] n_samples_i,
    input  logic        clear_i,
    input  logic        rd_en_i,
    output logic [31:0] rd_data_o,
    output logic        rd_valid_o,
    output logic [AW:0] fill_o,
    output logic        empty_o,
    output logic        full_o,
    output logic        capturing_o,
    output logic        done_o,
    output logic [31:0] captured_o,
    output logic        overflow_o,
    output logic        underflow_o,
    output logic [15:0] drop_cnt_o
);

    rx_sink_state_t state_q, state_d;
    logic [31:0]    target_q, target_d;
    logic [31:0]    captured_q, captured_d;
    logic           overflow_q, overflow_d;
    logic           underflow_q, underflow_d;
    logic [15:0]    drop_cnt_q, drop_cnt_d;

    logic fifo_full, fifo_empty;
    logic xfer, push_req, drop_evt, underflow_evt;
    logic unused_bits;

    assign unused_bits = ^{axis_tdata_i[15:0], axis_tdata_i[47:32]};

    // Only the backpressure flavour of CAPTURE ever deasserts tready.
    assign axis_tready_o = !rst &&
        !(state_q == CAPTURE && DROP_WHEN_FULL == 0 && fifo_full);

    assign xfer          = axis_tvalid_i && axis_tready_o;
    assign push_req      = (state_q == CAPTURE) && xfer && !fifo_full && !clear_i;
    assign drop_evt      = (state_q == CAPTURE) && xfer && fifo_full && !clear_i;
    assign underflow_evt = rd_en_i && fifo_empty && !clear_i;

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        captured_d  = captured_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        drop_cnt_d  = drop_cnt_q;

        if (push_req) captured_d = captured_q + 32'd1;

        if (clear_i) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            drop_cnt_d  = '0;
        end else begin
            if (drop_evt) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
            end
            if (underflow_evt) underflow_d = 1'b1;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d    = CAPTURE;
                    target_d   = n_samples_i;
                    captured_d = '0;
                end
            end
            CAPTURE: begin
                if (stop_i) begin
                    state_d = DONE;
                end else if (push_req && target_q != '0 &&
                             (captured_q + 32'd1) == target_q) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            target_q    <= '0;
            captured_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            captured_q  <= captured_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    sync_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (32)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (clear_i),
        .push_i     (push_req),
        .push_dat_i (rx_repack(axis_tdata_i)),
        .pop_i      (rd_en_i),
        .rd_dat_o   (rd_data_o),
        .rd_vld_o   (rd_valid_o),
        .fill_o     (fill_o),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign full_o      = fifo_full;
    assign empty_o     = fifo_empty;
    assign capturing_o = (state_q == CAPTURE);
    assign done_o      = (state_q == DONE);
    assign captured_o  = captured_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_rx_axis_sink.sv
// Drives one stimulus stream into a backpressure sink [0] and a drop-mode sink [1], both DEPTH 4,
// and checks both against a queue-based model every cycle plus hand-computed spot values.
module tb_rx_axis_sink;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] tdata;
    logic        tvalid, start, stop, clear, rd_en;
    logic [31:0] nsamp;

    logic        tready    [2];
    logic [31:0] rd_data   [2];
    logic        rd_valid  [2];
    logic [2:0]  fill      [2];
    logic        empty     [2];
    logic        full      [2];
    logic        capturing [2];
    logic        done      [2];
    logic [31:0] captured  [2];
    logic        ovf       [2];
    logic        udf       [2];
    logic [15:0] dropc     [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        rx_axis_sink #(.DEPTH(DEPTH), .DROP_WHEN_FULL(g)) u_dut (
            .clk           (clk),
            .rst           (rst),
            .axis_tdata_i  (tdata),
            .axis_tvalid_i (tvalid),
            .axis_tready_o (tready[g]),
            .start_i       (start),
            .stop_i        (stop),
            .n_samples_i   (nsamp),
            .clear_i       (clear),
            .rd_en_i       (rd_en),
            .rd_data_o     (rd_data[g]),
            .rd_valid_o    (rd_valid[g]),
            .fill_o        (fill[g]),
            .empty_o       (empty[g]),
            .full_o        (full[g]),
            .capturing_o   (capturing[g]),
            .done_o        (done[g]),
            .captured_o    (captured[g]),
            .overflow_o    (ovf[g]),
            .underflow_o   (udf[g]),
            .drop_cnt_o    (dropc[g])
        );
    end

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h want %0h at %0t", name, m, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] beat(input int k);
        return {16'h8000 + 16'(k), 16'h0000, 16'h0001 + 16'(k), 16'h0000};
    endfunction

    function automatic logic [31:0] word(input int k);
        return {16'h8000 + 16'(k), 16'h0001 + 16'(k)};
    endfunction

    // Model: state 0=idle 1=capture 2=done; the FIFO is a plain queue.
    int          m_st  [2];
    logic [31:0] m_tgt [2];
    logic [31:0] m_cap [2];
    logic        m_ovf [2];
    logic        m_udf [2];
    logic        m_rdv [2];
    logic [31:0] m_rdd [2];
    logic [15:0] m_drop[2];
    logic [31:0] mq    [2][$];

    function automatic logic model_rdy(input int m);
        if (rst) return 1'b0;
        if (m_st[m] == 1 && m == 0) return (mq[m].size() < DEPTH);
        return 1'b1;
    endfunction

    task automatic step_model(input int m);
        bit was_full, was_empty, xfer, hit;
        if (rst) begin
            m_st[m] = 0; mq[m].delete(); m_cap[m] = 0; m_tgt[m] = 0;
            m_ovf[m] = 0; m_udf[m] = 0; m_drop[m] = 0; m_rdv[m] = 0; m_rdd[m] = 0;
            return;
        end
        was_full  = (mq[m].size() == DEPTH);
        was_empty = (mq[m].size() == 0);
        xfer      = tvalid && model_rdy(m);
        hit       = 1'b0;
        m_rdv[m]  = 1'b0;
        if (clear) begin
            mq[m].delete();
            m_ovf[m] = 0; m_udf[m] = 0; m_drop[m] = 0;
        end else begin
            if (rd_en) begin
                if (was_empty) m_udf[m] = 1'b1;
                else begin
                    m_rdd[m] = mq[m].pop_front();
                    m_rdv[m] = 1'b1;
                end
            end
            if (m_st[m] == 1 && xfer) begin
                if (!was_full) begin
                    mq[m].push_back({tdata[63:48], tdata[31:16]});
                    m_cap[m] = m_cap[m] + 1;
                    hit = (m_tgt[m] != 0) && (m_cap[m] == m_tgt[m]);
                end else begin
                    m_ovf[m] = 1'b1;
                    if (m_drop[m] != 16'hFFFF) m_drop[m] = m_drop[m] + 1;
                end
            end
        end
        if (m_st[m] == 1) begin
            if (stop || hit) m_st[m] = 2;
        end else if (start) begin
            m_st[m] = 1; m_tgt[m] = nsamp; m_cap[m] = 0;
        end
    endtask

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) step_model(m);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int m = 0; m < 2; m++) begin
                chk("tready",    m, 32'(tready[m]),    32'(model_rdy(m)));
                chk("rd_valid",  m, 32'(rd_valid[m]),  32'(m_rdv[m]));
                chk("rd_data",   m, rd_data[m],        m_rdd[m]);
                chk("fill",      m, 32'(fill[m]),      32'(mq[m].size()));
                chk("empty",     m, 32'(empty[m]),     32'(mq[m].size() == 0));
                chk("full",      m, 32'(full[m]),      32'(mq[m].size() == DEPTH));
                chk("capturing", m, 32'(capturing[m]), 32'(m_st[m] == 1));
                chk("done",      m, 32'(done[m]),      32'(m_st[m] == 2));
                chk("captured",  m, captured[m],       m_cap[m]);
                chk("overflow",  m, 32'(ovf[m]),       32'(m_ovf[m]));
                chk("underflow", m, 32'(udf[m]),       32'(m_udf[m]));
                chk("drop_cnt",  m, 32'(dropc[m]),     32'(m_drop[m]));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int  k;
        bit  r;
        rst = 1'b1; tdata = '0; tvalid = 0; start = 0; stop = 0;
        nsamp = '0; clear = 0; rd_en = 0;

        // Reset
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_tready", 0, 32'(tready[0]), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_tready", 0, 32'(tready[0]), 32'd1);
        chk("idle_fill",   0, 32'(fill[0]),   32'd0);
        tick();

        // Backpressure vs drop: 6 valid cycles, no reads
        nsamp = 0; start = 1; tick(); start = 0;
        tvalid = 1; k = 0;
        for (int i = 0; i < 6; i++) begin
            tdata = beat(k);
            r = tready[0];
            tick();
            if (r) k++;
        end
        tvalid = 0;
        chk("bp_full",     0, 32'(full[0]),   32'd1);
        chk("bp_tready",   0, 32'(tready[0]), 32'd0);
        chk("bp_ovf",      0, 32'(ovf[0]),    32'd0);
        chk("bp_captured", 0, captured[0],    32'd4);
        chk("dr_fill",     1, 32'(fill[1]),   32'd4);
        chk("dr_drop",     1, 32'(dropc[1]),  32'd2);
        chk("dr_ovf",      1, 32'(ovf[1]),    32'd1);
        chk("dr_captured", 1, captured[1],    32'd4);

        rd_en = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pop_vld", 0, 32'(rd_valid[0]), 32'd1);
            chk("pop_dat", 0, rd_data[0], 32'h80000001 + 32'(i) * 32'h00010001);
            chk("pop_dat", 1, rd_data[1], 32'h80000001 + 32'(i) * 32'h00010001);
        end
        rd_en = 0;
        clear = 1; tick(); clear = 0;
        chk("clr_fill", 1, 32'(fill[1]),  32'd0);
        chk("clr_ovf",  1, 32'(ovf[1]),   32'd0);
        chk("clr_drop", 1, 32'(dropc[1]), 32'd0);
        chk("clr_fill", 0, 32'(fill[0]),  32'd0);

        // Underflow on an empty pop, then stop
        rd_en = 1; tick(); rd_en = 0;
        chk("udf",     0, 32'(udf[0]),      32'd1);
        chk("udf_vld", 0, 32'(rd_valid[0]), 32'd0);
        stop = 1; tick(); stop = 0;
        chk("stop_done", 0, 32'(done[0]), 32'd1);
        clear = 1; tick(); clear = 0;

        // Count limit of 3 with 10 valid beats
        nsamp = 3; start = 1; tick(); start = 0;
        tvalid = 1;
        for (int i = 0; i < 10; i++) begin
            tdata = beat(20 + i);
            tick();
            if (i == 1) chk("cnt_not_done", 0, 32'(done[0]), 32'd0);
            if (i == 2) begin
                chk("cnt_done",  0, 32'(done[0]), 32'd1);
                chk("cnt_fill",  0, 32'(fill[0]), 32'd3);
            end
        end
        tvalid = 0;
        chk("cnt_captured", 0, captured[0],    32'd3);
        chk("cnt_fill_end", 0, 32'(fill[0]),   32'd3);
        chk("cnt_tready",   0, 32'(tready[0]), 32'd1);

        // Simultaneous push and pop at fill 2, then at fill 0
        rd_en = 1; tick(); rd_en = 0;
        nsamp = 0; start = 1; tick(); start = 0;
        tvalid = 1; tdata = beat(30); rd_en = 1; tick();
        tvalid = 0; rd_en = 0;
        chk("pp2_fill", 0, 32'(fill[0]), 32'd2);
        chk("pp2_dat",  0, rd_data[0],   32'h80150016);
        clear = 1; tick(); clear = 0;
        tvalid = 1; tdata = beat(31); rd_en = 1; tick();
        tvalid = 0; rd_en = 0;
        chk("pp0_fill", 0, 32'(fill[0]),     32'd1);
        chk("pp0_udf",  0, 32'(udf[0]),      32'd1);
        chk("pp0_vld",  0, 32'(rd_valid[0]), 32'd0);

        // Wrap-around: 11 beats streamed with reads trailing by one
        clear = 1; tick(); clear = 0;
        for (int i = 0; i < 11; i++) begin
            tvalid = 1; tdata = beat(40 + i); rd_en = (i > 0);
            tick();
            if (i > 0) chk("wrap_dat", 0, rd_data[0], word(40 + i - 1));
        end
        tvalid = 0; rd_en = 1; tick(); rd_en = 0;
        chk("wrap_last", 0, rd_data[0],   word(50));
        chk("wrap_fill", 0, 32'(fill[0]), 32'd0);

        // Reset mid-capture with fill 3
        tvalid = 1;
        for (int i = 0; i < 3; i++) begin
            tdata = beat(60 + i);
            tick();
        end
        tvalid = 0;
        chk("pre_rst_fill", 0, 32'(fill[0]), 32'd3);
        rst = 1; tick(); rst = 0;
        #1;
        chk("rst_cap",  0, 32'(capturing[0]), 32'd0);
        chk("rst_fill", 0, 32'(fill[0]),      32'd0);
        chk("rst_ovf",  1, 32'(ovf[1]),       32'd0);
        chk("rst_udf",  0, 32'(udf[0]),       32'd0);
        tick();

        // start+stop together: from IDLE start wins, from CAPTURE stop wins
        start = 1; stop = 1; tick();
        chk("ss_idle", 0, 32'(capturing[0]), 32'd1);
        tick();
        chk("ss_cap",  0, 32'(done[0]),      32'd1);
        start = 0; stop = 0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
